// File: rtl/sync_fifo_ctrl.sv
// FIFO controller that drives an external dual-port synchronous RAM.
// It converts push/pop into RAM write/read strobes and tracks occupancy, status flags and sticky errors.
module sync_fifo_ctrl #(
    parameter int ram_width = 8,
    parameter int addr_size = 4,
    parameter int ram_depth = 16,
    parameter int af_level  = 14,
    parameter int ae_level  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [ram_width-1:0] push_data,
    input  logic                 pop,
    input  logic                 err_clr,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [addr_size:0]   count,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 ram_write_en,
    output logic [addr_size-1:0] ram_wr_addr,
    output logic [ram_width-1:0] ram_data_in,
    output logic                 ram_read_en,
    output logic [addr_size-1:0] ram_rd_addr,
    input  logic [ram_width-1:0] ram_data_out,
    output logic [ram_width-1:0] pop_data,
    output logic                 pop_valid
);

    localparam logic [addr_size:0] depth_c = (addr_size+1)'(ram_depth);
    localparam logic [addr_size:0] af_c    = (addr_size+1)'(af_level);
    localparam logic [addr_size:0] ae_c    = (addr_size+1)'(ae_level);

    logic [addr_size-1:0] wr_ptr;
    logic [addr_size-1:0] rd_ptr;
    logic [addr_size:0]   count_q;
    logic                 push_acc;
    logic                 pop_acc;

    // Flags come only from the registered count, so accepts never see a same-cycle bypass.
    assign full         = (count_q == depth_c);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= af_c);
    assign almost_empty = (count_q <= ae_c);
    assign count        = count_q;

    assign push_acc = push & ~full;
    assign pop_acc  = pop & ~empty;

    // A read needs count >= 1 and a write needs count < depth, so the two addresses never collide.
    assign ram_write_en = push_acc;
    assign ram_wr_addr  = wr_ptr;
    assign ram_data_in  = push_acc ? push_data : '0;
    assign ram_read_en  = pop_acc;
    assign ram_rd_addr  = rd_ptr;

    // The RAM registers data_out on the same edge that samples read_en.
    assign pop_data = ram_data_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + addr_size'(1);
            if (pop_acc)  rd_ptr <= rd_ptr + addr_size'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            case ({push_acc, pop_acc})
                2'b10:   count_q <= count_q + (addr_size+1)'(1);
                2'b01:   count_q <= count_q - (addr_size+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pop_valid <= 1'b0;
        end else begin
            pop_valid <= pop_acc;
        end
    end

    // A clear wins over a set that arrives in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (err_clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow | (push & full);
            underflow <= underflow | (pop & empty);
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: a behavioural RAM sits behind it, and a queue model supplies every expected value.
module tb_sync_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       push, pop, err_clr;
    logic [7:0] push_data;
    logic       full, empty, almost_full, almost_empty;
    logic [4:0] count;
    logic       overflow, underflow;
    logic       ram_write_en, ram_read_en;
    logic [3:0] ram_wr_addr, ram_rd_addr;
    logic [7:0] ram_data_in, ram_data_out, pop_data;
    logic       pop_valid;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    int  q[$];
    int  wr_n, rd_n;
    bit  m_ovf, m_udf, m_valid;
    int  m_data;

    logic [7:0] mem [16];

    sync_fifo_ctrl dut (
        .clk(clk), .reset(reset), .push(push), .push_data(push_data), .pop(pop),
        .err_clr(err_clr), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow),
        .underflow(underflow), .ram_write_en(ram_write_en), .ram_wr_addr(ram_wr_addr),
        .ram_data_in(ram_data_in), .ram_read_en(ram_read_en), .ram_rd_addr(ram_rd_addr),
        .ram_data_out(ram_data_out), .pop_data(pop_data), .pop_valid(pop_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_write_en) mem[ram_wr_addr] <= ram_data_in;
        if (ram_read_en)  ram_data_out <= mem[ram_rd_addr];
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        wr_n = 0; rd_n = 0;
        m_ovf = 0; m_udf = 0; m_valid = 0; m_data = 0;
    endtask

    task automatic check_state();
        int sz;
        sz = q.size();
        chk("count", int'(count), sz);
        chk("full", int'(full), int'(sz == 16));
        chk("empty", int'(empty), int'(sz == 0));
        chk("almost_full", int'(almost_full), int'(sz >= 14));
        chk("almost_empty", int'(almost_empty), int'(sz <= 2));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("underflow", int'(underflow), int'(m_udf));
        chk("pop_valid", int'(pop_valid), int'(m_valid));
        if (m_valid) chk("pop_data", int'(pop_data), m_data);
    endtask

    // One clock: check registered state, drive inputs, check RAM drive, advance the model.
    task automatic step(input bit p, input int d, input bit po, input bit ec);
        bit push_ok, pop_ok, was_full, was_empty;
        @(negedge clk);
        check_state();
        push = p; push_data = 8'(d); pop = po; err_clr = ec;
        #1;
        was_full  = (q.size() == 16);
        was_empty = (q.size() == 0);
        push_ok = p && !was_full;
        pop_ok  = po && !was_empty;
        chk("ram_write_en", int'(ram_write_en), int'(push_ok));
        chk("ram_read_en", int'(ram_read_en), int'(pop_ok));
        if (push_ok) begin
            chk("ram_wr_addr", int'(ram_wr_addr), wr_n % 16);
            chk("ram_data_in", int'(ram_data_in), d & 8'hFF);
        end
        if (pop_ok) chk("ram_rd_addr", int'(ram_rd_addr), rd_n % 16);
        m_valid = pop_ok;
        if (pop_ok) begin
            m_data = q.pop_front();
            rd_n++;
        end
        if (push_ok) begin
            q.push_back(d & 8'hFF);
            wr_n++;
        end
        if (ec) begin
            m_ovf = 0; m_udf = 0;
        end else begin
            m_ovf = m_ovf | (p && was_full);
            m_udf = m_udf | (po && was_empty);
        end
    endtask

    initial begin
        reset = 1'b0; push = 0; pop = 0; err_clr = 0; push_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_state();
        reset = 1'b1;

        // Fill with 1..16
        for (int i = 1; i <= 16; i++) step(1, i, 0, 0);
        // Push on full, then clear the sticky flag
        step(1, 8'h55, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        // Drain
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        // Pop on empty, then push+pop on empty
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        step(1, 8'h3C, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 1);
        // Steady state at count 8 with pointer wrap
        for (int i = 0; i < 8; i++) step(1, $urandom_range(0, 255), 0, 0);
        for (int i = 0; i < 20; i++) step(1, $urandom_range(0, 255), 1, 0);
        step(0, 0, 0, 0);
        // Random traffic
        for (int i = 0; i < 400; i++)
            step(($urandom % 100) < 55, $urandom_range(0, 255),
                 ($urandom % 100) < 45, ($urandom % 100) < 5);
        for (int i = 0; i < 20; i++) step(0, 0, 1, 1);
        step(0, 0, 0, 0);

        // Asynchronous reset mid-burst at count 5 while pop_valid is high
        for (int i = 0; i < 6; i++) step(1, 16 + i, 0, 0);
        step(1, 8'h77, 1, 0);
        step(0, 0, 1, 0);
        @(posedge clk);
        #2;
        chk("pre_reset_pop_valid", int'(pop_valid), 1);
        chk("pre_reset_count", int'(count), q.size());
        push = 0; pop = 0; err_clr = 0;
        reset = 1'b0;
        model_reset();
        #1;
        check_state();
        @(negedge clk);
        reset = 1'b1;
        step(1, 8'hAA, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("post_reset_data", int'(pop_data), 8'hAA);
        step(0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Synchronous FIFO controller that sits directly upstream of dual_port_sync_ram and drives both of its ports.
- Converts a push/pop handshake into RAM write_en/wr_addr/data_in and read_en/rd_addr.
- Tracks occupancy, raises status flags and returns RAM read data with a valid strobe.
- The RAM instance is external; this block contains no storage array.

Parameters:
ram_width, 8, data width; matches the RAM.
addr_size, 4, pointer/address width.
ram_depth, 16, entry count; must equal 2**addr_size.
af_level, 14, almost_full asserts when count >= af_level.
ae_level, 2, almost_empty asserts when count <= ae_level.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset (0 = reset).
push  input  1  write request.
push_data  input  ram_width  data to write.
pop  input  1  read request.
err_clr  input  1  synchronous clear of the sticky error flags.
full  output  1  count == ram_depth.
empty  output  1  count == 0.
almost_full  output  1  count >= af_level.
almost_empty  output  1  count <= ae_level.
count  output  addr_size+1  occupancy, 0..ram_depth.
overflow  output  1  sticky: push was rejected.
underflow  output  1  sticky: pop was rejected.
ram_write_en  output  1  to RAM write_en.
ram_wr_addr  output  addr_size  to RAM wr_addr.
ram_data_in  output  ram_width  to RAM data_in.
ram_read_en  output  1  to RAM read_en.
ram_rd_addr  output  addr_size  to RAM rd_addr.
ram_data_out  input  ram_width  from RAM data_out.
pop_data  output  ram_width  read data; equals ram_data_out.
pop_valid  output  1  pop_data valid this cycle.

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr, rd_ptr, count = 0; pop_valid = 0; overflow = underflow = 0.
  - Flags: empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - Applies immediately, mid-operation included. Any in-flight pop_valid is dropped.
  - RAM contents are not cleared; they are unreachable because pointers restart at 0.
- Accept rules:
  - push_acc = push & ~full.
  - pop_acc = pop & ~empty.
  - Both are evaluated on registered flags; there is no bypass.
  - Full with push and pop together: pop accepted, push rejected, overflow set.
  - Empty with push and pop together: push accepted, pop rejected, underflow set.
- RAM drive (combinational from accepts and pointers):
  - ram_write_en = push_acc; ram_wr_addr = wr_ptr; ram_data_in = push_data.
  - ram_read_en = pop_acc; ram_rd_addr = rd_ptr.
  - All are 0 or idle when there is no accept.
- Pointers:
  - wr_ptr += 1 on push_acc; rd_ptr += 1 on pop_acc.
  - Both wrap modulo ram_depth (15 -> 0) with no extra logic.
- Count:
  - +1 on push_acc only; -1 on pop_acc only.
  - Unchanged when both are accepted or neither is.
  - Never leaves 0..ram_depth.
- Flags are combinational decodes of registered count and change the cycle after the causing edge.
- No RAM collision: a same-cycle read and write always hit different addresses.
  - A read needs count >= 1 and a write needs count < ram_depth, so rd_ptr != wr_ptr whenever both are enabled.
- Read latency:
  - The RAM registers data_out on the edge that samples read_en.
  - pop_valid is a flop of pop_acc: it is high for exactly the cycle after the accepted pop.
  - pop_data is ram_data_out passed through.
- Error flags:
  - overflow is set on push & full; underflow is set on pop & empty.
  - Both hold until err_clr=1 or reset.
  - err_clr has priority over a same-cycle set.
- Pass-through behaviour: a push into an empty FIFO becomes poppable the next cycle, when empty=0.
- Constraint: af_level and ae_level must lie within 0..ram_depth. Larger or smaller values are not supported.

Test Plan:
1. After reset, 16 consecutive pushes of 1..16 -> ram_wr_addr steps 0..15; almost_empty drops after the 3rd push; almost_full rises after the 14th; full=1 and count=16 after the 16th.
2. With the FIFO full, push=1 for one cycle -> no ram_write_en; overflow=1 and stays 1; err_clr pulse -> overflow=0.
3. From full, 16 pops -> pop_valid one cycle after each pop; pop_data = 1..16 in order; empty=1 and count=0 at the end.
4. Pop on empty -> ram_read_en=0, pop_valid=0, underflow=1. Push and pop together on empty -> count=1, underflow=1.
5. With count=8, push and pop together for 20 cycles -> count stays 8; both pointers wrap past 15 -> 0; popped data matches push order.
6. Drive reset=0 mid-burst at count=5 with pop_valid high -> all outputs take reset values immediately, with no clock edge. After release, push 0xAA then pop -> pop_data = 0xAA, ram_rd_addr = 0.
